// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage data memory access unit.
// Contents: access-size and FSM state encodings, the little-endian
// lane-select constant, and small decode helpers.
package mem_access_unit_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned OFFSET_WIDTH = 2;
  localparam int unsigned SHIFT_WIDTH  = 5;
  // Little-endian lane select: byte offset k occupies bits [8k+7:8k],
  // so the bit shift for an offset is offset << LANE_SHIFT.
  localparam int unsigned LANE_SHIFT   = 3;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } memSizeT;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_DONE   = 3'd4
  } memStateT;

  // Bit shift that moves lane 'offset' down to bit 0.
  function automatic logic [SHIFT_WIDTH-1:0] laneShift(input logic [OFFSET_WIDTH-1:0] offset);
    return SHIFT_WIDTH'(offset) << LANE_SHIFT;
  endfunction

  // Rejected accesses: unaligned half/word, or the reserved size code.
  function automatic logic isMisaligned(input memSizeT size, input logic [OFFSET_WIDTH-1:0] offset);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = offset[0];
      SZ_WORD: err = (offset != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment for sub-word accesses.
// Ports:
//   readWord    - word read from memory (load path)
//   oldWord     - previously read word (store merge path)
//   storeData   - right-justified store data
//   offset      - byte offset within the word
//   size        - access size
//   signExt     - sign-extend loads when 1
//   loadData_c  - extracted and extended load result
//   mergeWord_c - oldWord with the addressed lane replaced by storeData
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   readWord,
  input  logic [DATA_WIDTH-1:0]   oldWord,
  input  logic [DATA_WIDTH-1:0]   storeData,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  memSizeT                 size,
  input  logic                    signExt,
  output logic [DATA_WIDTH-1:0]   loadData_c,
  output logic [DATA_WIDTH-1:0]   mergeWord_c
);

  // Shift the addressed lane to bit 0, then extend to a full word.
  function automatic logic [DATA_WIDTH-1:0] loadExtract(
    input logic [DATA_WIDTH-1:0]   word,
    input logic [OFFSET_WIDTH-1:0] off,
    input memSizeT                 sz,
    input logic                    sgn
  );
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] res;
    sh = word >> laneShift(off);
    case (sz)
      SZ_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
      default: res = sh;  // word accesses are aligned, so shift is zero
    endcase
    return res;
  endfunction

  // Replace only the addressed lane; all other bytes keep their old value.
  function automatic logic [DATA_WIDTH-1:0] storeMerge(
    input logic [DATA_WIDTH-1:0]   old,
    input logic [DATA_WIDTH-1:0]   data,
    input logic [OFFSET_WIDTH-1:0] off,
    input memSizeT                 sz
  );
    logic [DATA_WIDTH-1:0] mask;
    case (sz)
      SZ_BYTE: mask = 32'h0000_00FF << laneShift(off);
      SZ_HALF: mask = 32'h0000_FFFF << laneShift(off);
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old & ~mask) | ((data << laneShift(off)) & mask);
  endfunction

  assign loadData_c  = loadExtract(readWord, offset, size, signExt);
  assign mergeWord_c = storeMerge(oldWord, storeData, offset, size);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a single-port, word-addressed data memory.
// Accepts one load/store at a time; sub-word stores use read-modify-write.
// Ports:
//   Clk, Reset            - clock, async active-high reset
//   ReqValid/ReqReady     - request handshake (ready only in IDLE)
//   ReqWrite, ReqSize,
//   ReqSigned, ReqAddr,
//   ReqWData              - request fields, latched on accept
//   RespValid, RespData,
//   MisalignErr           - one-cycle completion with load data / error flag
//   Busy                  - access in flight
//   MemAddress, MemWriteData,
//   MemWrite, MemRead,
//   MemReadData           - data memory interface
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [1:0]            ReqSize,
  input  logic                  ReqSigned,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqWData,
  output logic                  RespValid,
  output logic [DATA_WIDTH-1:0] RespData,
  output logic                  MisalignErr,
  output logic                  Busy,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] MemReadData
);

  memStateT              state;
  memStateT              stateNext;
  logic                  reqWrite;
  memSizeT               reqSize;
  logic                  reqSigned;
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [DATA_WIDTH-1:0] reqWData;
  logic [DATA_WIDTH-1:0] rdWord;
  logic [DATA_WIDTH-1:0] respData;
  logic                  misalignErr;
  logic                  acceptErr;
  logic [DATA_WIDTH-1:0] loadData;
  logic [DATA_WIDTH-1:0] mergeWord;

  assign acceptErr   = isMisaligned(memSizeT'(ReqSize), ReqAddr[1:0]);
  assign MemAddress  = {reqAddr[ADDR_WIDTH-1:2], 2'b00};
  assign RespData    = respData;
  assign MisalignErr = misalignErr;

  mem_lane_align uLaneAlign (
    .readWord    (MemReadData),
    .oldWord     (rdWord),
    .storeData   (reqWData),
    .offset      (reqAddr[1:0]),
    .size        (reqSize),
    .signExt     (reqSigned),
    .loadData_c  (loadData),
    .mergeWord_c (mergeWord)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    stateNext    = state;
    ReqReady     = 1'b0;
    Busy         = 1'b1;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemWriteData = '0;
    RespValid    = 1'b0;
    case (state)
      ST_IDLE: begin
        ReqReady = 1'b1;
        Busy     = 1'b0;
        if (ReqValid) begin
          if (acceptErr) begin
            stateNext = ST_DONE;
          end else if (ReqWrite && (memSizeT'(ReqSize) != SZ_WORD)) begin
            stateNext = ST_RMW_RD;
          end else begin
            stateNext = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        MemRead   = !reqWrite;
        MemWrite  = reqWrite;
        if (reqWrite) begin
          MemWriteData = reqWData;
        end
        stateNext = ST_DONE;
      end
      ST_RMW_RD: begin
        MemRead   = 1'b1;
        stateNext = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        MemWrite     = 1'b1;
        MemWriteData = mergeWord;
        stateNext    = ST_DONE;
      end
      ST_DONE: begin
        RespValid = 1'b1;
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Request latch, RMW read capture and response registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      reqWrite    <= 1'b0;
      reqSize     <= SZ_BYTE;
      reqSigned   <= 1'b0;
      reqAddr     <= '0;
      reqWData    <= '0;
      rdWord      <= '0;
      respData    <= '0;
      misalignErr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ReqValid) begin
            reqWrite    <= ReqWrite;
            reqSize     <= memSizeT'(ReqSize);
            reqSigned   <= ReqSigned;
            reqAddr     <= ReqAddr;
            reqWData    <= ReqWData;
            respData    <= '0;
            misalignErr <= acceptErr;
          end
        end
        ST_ACCESS: begin
          if (!reqWrite) begin
            respData <= loadData;
          end
        end
        ST_RMW_RD: begin
          rdWord <= MemReadData;
        end
        ST_DONE: begin
          respData    <= '0;
          misalignErr <= 1'b0;
        end
        default: begin
          respData <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural
// single-port data memory (combinational read, write on rising Clk).
module tb_mem_access_unit;

  logic        Clk;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespData;
  logic        MisalignErr;
  logic        Busy;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;

  logic [31:0] mem [0:15];

  int nVec;
  int nErr;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .ReqSize      (ReqSize),
    .ReqSigned    (ReqSigned),
    .ReqAddr      (ReqAddr),
    .ReqWData     (ReqWData),
    .RespValid    (RespValid),
    .RespData     (RespData),
    .MisalignErr  (MisalignErr),
    .Busy         (Busy),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign MemReadData = MemRead ? mem[MemAddress[5:2]] : 32'h0;

  always @(posedge Clk) begin
    if (MemWrite) mem[MemAddress[5:2]] <= MemWriteData;
  end

  // Issue one request (ReqValid held until the response) and observe it.
  // Cycle k = the k-th cycle after the accept edge.
  task automatic runReq(
    input  logic        w,
    input  logic [1:0]  sz,
    input  logic        sg,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output int          lat,
    output int          nRd,
    output int          nWr,
    output int          rdAt,
    output int          wrAt,
    output logic [31:0] wrData,
    output logic [31:0] rData,
    output logic        err,
    output int          viol
  );
    lat = 99; nRd = 0; nWr = 0; rdAt = 0; wrAt = 0;
    wrData = 32'h0; rData = 32'hDEAD_BEEF; err = 1'bx; viol = 0;
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg;
    ReqAddr = addr; ReqWData = wd;
    @(posedge Clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (MemRead) begin nRd++; rdAt = k; end
      if (MemWrite) begin nWr++; wrAt = k; wrData = MemWriteData; end
      if (MemRead && MemWrite) viol++;
      if (Busy === ReqReady) viol++;
      if ((MemRead || MemWrite) && (MemAddress !== {addr[31:2], 2'b00})) viol++;
      if (RespValid) begin
        lat = k; rData = RespData; err = MisalignErr;
        ReqValid = 1'b0;
        break;
      end
    end
    ReqValid = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
    ReqSigned = 1'b0; ReqAddr = 32'h0; ReqWData = 32'h0;
    repeat (2) @(negedge Clk);
    nVec++;
    if (ReqReady !== 1'b1 || Busy !== 1'b0 || RespValid !== 1'b0 || MisalignErr !== 1'b0) begin
      nErr++;
      $display("FAIL reset_ctrl: ready=%b busy=%b rv=%b err=%b, expected 1 0 0 0",
               ReqReady, Busy, RespValid, MisalignErr);
    end
    nVec++;
    if (MemRead !== 1'b0 || MemWrite !== 1'b0 || RespData !== 32'h0 ||
        MemAddress !== 32'h0 || MemWriteData !== 32'h0) begin
      nErr++;
      $display("FAIL reset_data: rd=%b wr=%b data=%h addr=%h wdata=%h, expected all zero",
               MemRead, MemWrite, RespData, MemAddress, MemWriteData);
    end
    Reset = 1'b0;
  endtask

  task automatic test_word_round_trip;
    int lat, nRd, nWr, rdAt, wrAt, viol;
    logic [31:0] wrData, rData;
    logic err;
    runReq(1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678, lat, nRd, nWr, rdAt, wrAt, wrData, rData, err, viol);
    nVec++;
    if (lat !== 2 || nWr !== 1 || nRd !== 0 || wrData !== 32'h1234_5678 || err !== 1'b0 || rData !== 32'h0 || viol !== 0) begin
      nErr++;
      $display("FAIL word_store: lat=%0d wr=%0d rd=%0d wdata=%h err=%b data=%h viol=%0d, expected 2 1 0 12345678 0 0 0",
               lat, nWr, nRd, wrData, err, rData, viol);
    end
    runReq(1'b0, 2'b10, 1'b1, 32'h0, 32'h0, lat, nRd, nWr, rdAt, wrAt, wrData, rData, err, viol);
    nVec++;
    if (lat !== 2 || nRd !== 1 || nWr !== 0 || rData !== 32'h1234_5678 || err !== 1'b0 || viol !== 0) begin
      nErr++;
      $display("FAIL word_load: lat=%0d rd=%0d wr=%0d data=%h err=%b viol=%0d, expected 2 1 0 12345678 0 0",
               lat, nRd, nWr, rData, err, viol);
    end
  endtask

  task automatic test_byte_store_rmw;
    int lat, nRd, nWr, rdAt, wrAt, viol;
    logic [31:0] wrData, rData;
    logic err;
    runReq(1'b1, 2'b00, 1'b0, 32'h1, 32'hFFFF_FFAB, lat, nRd, nWr, rdAt, wrAt, wrData, rData, err, viol);
    nVec++;
    if (lat !== 3 || nRd !== 1 || nWr !== 1 || rdAt !== 1 || wrAt !== 2 || viol !== 0) begin
      nErr++;
      $display("FAIL byte_rmw_seq: lat=%0d rd=%0d@%0d wr=%0d@%0d viol=%0d, expected 3 1@1 1@2 0",
               lat, nRd, rdAt, nWr, wrAt, viol);
    end
    nVec++;
    if (wrData !== 32'h1234_AB78 || mem[0] !== 32'h1234_AB78 || rData !== 32'h0 || err !== 1'b0) begin
      nErr++;
      $display("FAIL byte_rmw_data: wdata=%h mem=%h data=%h err=%b, expected 1234ab78 1234ab78 0 0",
               wrData, mem[0], rData, err);
    end
  endtask

  task automatic test_byte_loads;
    int lat, nRd, nWr, rdAt, wrAt, viol;
    logic [31:0] wrData, rData;
    logic err;
    runReq(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, lat, nRd, nWr, rdAt, wrAt, wrData, rData, err, viol);
    nVec++;
    if (lat !== 2 || rData !== 32'hFFFF_FFAB || err !== 1'b0 || nWr !== 0 || viol !== 0) begin
      nErr++;
      $display("FAIL byte_load_signed: lat=%0d data=%h err=%b wr=%0d viol=%0d, expected 2 ffffffab 0 0 0",
               lat, rData, err, nWr, viol);
    end
    runReq(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, lat, nRd, nWr, rdAt, wrAt, wrData, rData, err, viol);
    nVec++;
    if (lat !== 2 || rData !== 32'h0000_00AB || err !== 1'b0) begin
      nErr++;
      $display("FAIL byte_load_unsigned: lat=%0d data=%h err=%b, expected 2 000000ab 0",
               lat, rData, err);
    end
  endtask

  task automatic test_half;
    int lat, nRd, nWr, rdAt, wrAt, viol;
    logic [31:0] wrData, rData;
    logic err;
    runReq(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_FFFF, lat, nRd, nWr, rdAt, wrAt, wrData, rData, err, viol);
    nVec++;
    if (lat !== 3 || wrData !== 32'hFFFF_AB78 || mem[0] !== 32'hFFFF_AB78 || viol !== 0) begin
      nErr++;
      $display("FAIL half_store: lat=%0d wdata=%h mem=%h viol=%0d, expected 3 ffffab78 ffffab78 0",
               lat, wrData, mem[0], viol);
    end
    runReq(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, lat, nRd, nWr, rdAt, wrAt, wrData, rData, err, viol);
    nVec++;
    if (lat !== 2 || rData !== 32'hFFFF_FFFF || err !== 1'b0) begin
      nErr++;
      $display("FAIL half_load_signed: lat=%0d data=%h err=%b, expected 2 ffffffff 0", lat, rData, err);
    end
    runReq(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, lat, nRd, nWr, rdAt, wrAt, wrData, rData, err, viol);
    nVec++;
    if (lat !== 2 || rData !== 32'h0000_FFFF || err !== 1'b0) begin
      nErr++;
      $display("FAIL half_load_unsigned: lat=%0d data=%h err=%b, expected 2 0000ffff 0", lat, rData, err);
    end
  endtask

  task automatic test_misaligned;
    logic        wv [3];
    logic [1:0]  sv [3];
    logic [31:0] av [3];
    int lat, nRd, nWr, rdAt, wrAt, viol;
    logic [31:0] wrData, rData;
    logic err;
    wv[0] = 1'b0; sv[0] = 2'b01; av[0] = 32'h3;
    wv[1] = 1'b1; sv[1] = 2'b10; av[1] = 32'h6;
    wv[2] = 1'b0; sv[2] = 2'b11; av[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      runReq(wv[i], sv[i], 1'b1, av[i], 32'hCAFE_F00D, lat, nRd, nWr, rdAt, wrAt, wrData, rData, err, viol);
      nVec++;
      if (lat !== 1 || err !== 1'b1 || rData !== 32'h0 || nRd !== 0 || nWr !== 0 || viol !== 0) begin
        nErr++;
        $display("FAIL misalign_%0d: lat=%0d err=%b data=%h rd=%0d wr=%0d viol=%0d, expected 1 1 0 0 0 0",
                 i, lat, err, rData, nRd, nWr, viol);
      end
    end
    nVec++;
    if (mem[1] === 32'hCAFE_F00D || mem[0] !== 32'hFFFF_AB78) begin
      nErr++;
      $display("FAIL misalign_mem: mem1=%h mem0=%h, expected mem1 unwritten, mem0 ffffab78", mem[1], mem[0]);
    end
  endtask

  task automatic test_reset_rmw;
    int lat, nRd, nWr, rdAt, wrAt, viol;
    logic [31:0] wrData, rData;
    logic err;
    int wrSeen;
    runReq(1'b1, 2'b10, 1'b0, 32'h8, 32'hFFFF_FFFF, lat, nRd, nWr, rdAt, wrAt, wrData, rData, err, viol);
    nVec++;
    if (mem[2] !== 32'hFFFF_FFFF || lat !== 2) begin
      nErr++;
      $display("FAIL rst_preload: mem=%h lat=%0d, expected ffffffff 2", mem[2], lat);
    end
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b00; ReqSigned = 1'b0;
    ReqAddr = 32'h8; ReqWData = 32'h0000_0000;
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    #2;
    nVec++;
    if (MemRead !== 1'b1 || MemWrite !== 1'b0 || Busy !== 1'b1) begin
      nErr++;
      $display("FAIL rst_in_rmw_rd: rd=%b wr=%b busy=%b, expected 1 0 1", MemRead, MemWrite, Busy);
    end
    Reset = 1'b1;
    #1;
    nVec++;
    if (MemRead !== 1'b0 || MemWrite !== 1'b0 || Busy !== 1'b0 || ReqReady !== 1'b1) begin
      nErr++;
      $display("FAIL rst_async: rd=%b wr=%b busy=%b ready=%b, expected 0 0 0 1",
               MemRead, MemWrite, Busy, ReqReady);
    end
    wrSeen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (MemWrite) wrSeen++;
    end
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (MemWrite) wrSeen++;
    end
    nVec++;
    if (wrSeen !== 0 || mem[2] !== 32'hFFFF_FFFF) begin
      nErr++;
      $display("FAIL rst_no_write: writes=%0d mem=%h, expected 0 ffffffff", wrSeen, mem[2]);
    end
    nVec++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0 || RespData !== 32'h0 || MisalignErr !== 1'b0 ||
        MemAddress !== 32'h0 || MemWriteData !== 32'h0 || MemRead !== 1'b0 || Busy !== 1'b0) begin
      nErr++;
      $display("FAIL rst_release: ready=%b rv=%b data=%h err=%b addr=%h wdata=%h rd=%b busy=%b, expected 1 0 0 0 0 0 0 0",
               ReqReady, RespValid, RespData, MisalignErr, MemAddress, MemWriteData, MemRead, Busy);
    end
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
    test_reset();
    test_word_round_trip();
    test_byte_store_rmw();
    test_byte_loads();
    test_half();
    test_misaligned();
    test_reset_rmw();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator that drives the single-port DataMemory (word-addressed by byte address, combinational read while MemRead=1, write on rising Clk while MemWrite=1).
- Accepts one load/store request at a time from the EX/MEM register and supports word, halfword and byte sizes.
- Sub-word stores use a read-modify-write sequence; loads return sign- or zero-extended data.
- Busy output stalls the pipeline while an access is in flight.

Parameters:
- ADDR_WIDTH, 32, byte-address width of request and memory address.

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  unit can accept (high only in IDLE)
- ReqWrite  in  1  1=store, 0=load
- ReqSize  in  2  00 byte, 01 half, 10 word, 11 illegal
- ReqSigned  in  1  load sign-extend when 1
- ReqAddr  in  ADDR_WIDTH  byte address
- ReqWData  in  32  store data, right-justified
- RespValid  out  1  one-cycle completion pulse
- RespData  out  32  load result (0 for stores/errors)
- MisalignErr  out  1  qualifies RespValid; access was rejected
- Busy  out  1  state != IDLE
- MemAddress  out  ADDR_WIDTH  {ReqAddr[ADDR_WIDTH-1:2],2'b00} of latched request
- MemWriteData  out  32  full word to write
- MemWrite  out  1  write strobe
- MemRead  out  1  read enable
- MemReadData  in  32  memory read data, valid same cycle as MemRead

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high, ports Clk and Reset.
  - Reset forces state IDLE and clears every register.
  - All outputs are 0 during and after reset, except ReqReady, which is 1 once in IDLE.
  - MemRead and MemWrite are decoded from registered state only, so reset deasserts them immediately.
- Byte order is little-endian: offset ReqAddr[1:0]=0 maps to bits [7:0].
- Accept: when ReqValid&&ReqReady at edge N, latch all Req* fields. ReqReady and Busy then follow state; no new request is accepted until the return to IDLE.
- Alignment check at accept:
  - half with addr[0]=1, word with addr[1:0]!=0, or size 11 is an error.
  - An error goes to DONE at N+1 with MisalignErr=1 and RespData=0.
  - An error never asserts MemRead or MemWrite.
- States: IDLE, ACCESS, RMW_RD, RMW_WR, DONE.
  - IDLE -> ACCESS for a load, or for a word store.
  - IDLE -> RMW_RD for a byte or half store.
  - IDLE -> DONE on error.
  - ACCESS, load: MemRead=1. The extracted lane is sign/zero-extended per ReqSigned and registered into RespData at the end edge. ACCESS -> DONE.
  - ACCESS, word store: MemWrite=1 for exactly one cycle, MemWriteData=ReqWData. ACCESS -> DONE.
  - RMW_RD: MemRead=1; the read word is registered. RMW_RD -> RMW_WR.
  - RMW_WR: MemWrite=1. MemWriteData = stored word with the addressed byte or half lane replaced by ReqWData[7:0] or ReqWData[15:0]; other lanes are untouched. RMW_WR -> DONE.
  - DONE: RespValid=1 for one cycle; RespData holds for that cycle. DONE -> IDLE unconditionally.
- Word and signed flags: a word load ignores ReqSigned. Stores return RespData=0.
- Latencies from accept edge N:
  - load or word store: RespValid in cycle N+2.
  - sub-word store: RespValid in cycle N+3, memory updated at edge entering DONE.
  - error: RespValid in cycle N+1.
- Exclusivity: MemRead and MemWrite are never both 1.
- MemAddress is held stable for the whole access.
- Reset mid-operation: any in-flight access is abandoned. A reset during RMW_RD produces no write; memory is unchanged.
- ReqValid while Busy is ignored; the upstream stage holds its request.

Decomposition:
- Shared package/header:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state encodings
  - the little-endian lane-select constant
- One natural sub-module, mem_lane_align. It is purely combinational and contains:
  - the load extract + extend function (word, offset, size, signed)
  - the store merge function (old word, new data, offset, size)
- The FSM stays in mem_access_unit.

Test Plan:
- Word round trip:
  - Stimulus: word store 0x12345678 @0x0, then word load @0x0.
  - Required: one MemWrite cycle, then RespData=0x12345678 at N+2 with MisalignErr=0.
- Byte store via RMW:
  - Stimulus: byte store 0xAB @0x1 over 0x12345678.
  - Required: MemRead for one cycle then MemWrite with MemWriteData=0x1234AB78; RespValid at N+3.
- Byte loads @0x1:
  - Stimulus: signed byte load, then unsigned byte load.
  - Required: 0xFFFFFFAB, then 0x000000AB.
- Half store and loads @0x2:
  - Stimulus: half store 0xFFFF, then signed half load and unsigned half load.
  - Required: word becomes 0xFFFFAB78; loads return 0xFFFFFFFF and 0x0000FFFF.
- Misaligned and illegal requests:
  - Stimulus: half load @0x3, word store @0x6, size 11 @0x0.
  - Required: each gives RespValid at N+1 with MisalignErr=1 and RespData=0; MemRead/MemWrite never asserted.
- Reset during RMW:
  - Stimulus: assert Reset asynchronously while in RMW_RD of a byte store to 0x8 (holding 0xFFFFFFFF).
  - Required: MemWrite never rises, word @0x8 still 0xFFFFFFFF, outputs 0, ReqReady=1 after release.
